// File: rtl/shift_reg_2_pkg.sv
// Shared types for shift_reg_2: shift mode decode and per-stage next-value select.
package shift_reg_2_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UP     = 2'b10,
        MODE_CENTRE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_BELOW = 2'b01,
        SEL_ABOVE = 2'b10,
        SEL_DIN   = 2'b11
    } stage_sel_e;

    function automatic mode_e decode_mode(input logic up_en, input logic down_en);
        mode_e mode;
        case ({up_en, down_en})
            2'b00:   mode = MODE_HOLD;
            2'b01:   mode = MODE_DOWN;
            2'b10:   mode = MODE_UP;
            2'b11:   mode = MODE_CENTRE;
            default: mode = MODE_HOLD;
        endcase
        return mode;
    endfunction

    // Where stage idx takes its next value from; "below" is idx-1, "above" is idx+1.
    function automatic stage_sel_e stage_sel(input mode_e mode, input int idx,
                                             input int n, input int c);
        stage_sel_e sel;
        case (mode)
            MODE_HOLD:   sel = SEL_HOLD;
            MODE_UP:     sel = (idx == 32'sd0) ? SEL_DIN : SEL_BELOW;
            MODE_DOWN:   sel = (idx == n - 32'sd1) ? SEL_DIN : SEL_ABOVE;
            MODE_CENTRE: begin
                if (idx == c) begin
                    sel = SEL_DIN;
                end else if (idx > c) begin
                    sel = SEL_BELOW;
                end else begin
                    sel = SEL_ABOVE;
                end
            end
            default:     sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_reg_2_if.sv
// Shift-control and tap bus of shift_reg_2; master drives enables/din, slave exposes every stage.
interface shift_reg_2_if #(
    parameter int N = 11,
    parameter int B = 8
);
    logic         up_en;
    logic         down_en;
    logic [B-1:0] din;
    logic [B-1:0] dout [N-1:0];

    modport master (output up_en, output down_en, output din, input dout);
    modport slave  (input up_en, input down_en, input din, output dout);
endinterface

// File: rtl/shift_reg_2_stage.sv
// One B-bit stage: async clear and a 4:1 next-value mux (hold / below / above / din).
module shift_reg_2_stage
    import shift_reg_2_pkg::*;
#(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  stage_sel_e   sel,
    input  logic [B-1:0] below,
    input  logic [B-1:0] above,
    input  logic [B-1:0] din,
    output logic [B-1:0] q_r
);

    // Stage register with selected next value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r <= {B{1'b0}};
        end else begin
            case (sel)
                SEL_HOLD:  q_r <= q_r;
                SEL_BELOW: q_r <= below;
                SEL_ABOVE: q_r <= above;
                SEL_DIN:   q_r <= din;
                default:   q_r <= q_r;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_2.sv
// N-stage, B-bit shift register shifting up, down or outward from stage N/2, all taps visible.
module shift_reg_2
    import shift_reg_2_pkg::*;
#(
    parameter int N = 11,
    parameter int B = 8
) (
    input  logic          clk,
    input  logic          rstn,
    shift_reg_2_if.slave  bus
);

    localparam int C = N / 2;

    mode_e        mode_s;
    logic [B-1:0] stage_r [N-1:0];

    // Mode is decoded fresh every cycle; no history is kept.
    always_comb begin
        mode_s = decode_mode(bus.up_en, bus.down_en);
    end

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic [B-1:0] below_s;
        logic [B-1:0] above_s;
        stage_sel_e   sel_s;

        // End stages have no neighbour on one side; din fills the slot, never selected there.
        if (i == 0) begin : g_lo_end
            assign below_s = bus.din;
        end else begin : g_lo_mid
            assign below_s = stage_r[i-1];
        end
        if (i == N - 1) begin : g_hi_end
            assign above_s = bus.din;
        end else begin : g_hi_mid
            assign above_s = stage_r[i+1];
        end

        // Per-stage source select for the current mode.
        always_comb begin
            sel_s = stage_sel(mode_s, i, N, C);
        end

        shift_reg_2_stage #(.B(B)) u_stage (
            .clk   (clk),
            .rstn  (rstn),
            .sel   (sel_s),
            .below (below_s),
            .above (above_s),
            .din   (bus.din),
            .q_r   (stage_r[i])
        );
    end

    assign bus.dout = stage_r;

endmodule

// File: tb/tb_shift_reg_2.sv
// Self-checking bench for shift_reg_2: directed mode scenarios plus randomized run against a model.
module tb_shift_reg_2;

    localparam int N = 11;
    localparam int B = 8;
    localparam int C = N / 2;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_mis;

    shift_reg_2_if #(.N(N), .B(B)) bus ();

    shift_reg_2 #(.N(N), .B(B)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] v(input int k);
        return 8'((3 + 13 * k) % 256);
    endfunction

    task automatic test_reset();
        rstn        = 1'b0;
        bus.din     = 8'd3;
        bus.up_en   = 1'b0;
        bus.down_en = 1'b0;
        #2;
        for (int c = 0; c < 4; c++) begin
            bus.up_en   = c[0];
            bus.down_en = c[1];
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (bus.dout[k] !== 8'd0) begin
                    n_mis++;
                    $display("FAIL reset_edge dout[%0d] got %0d exp 0", k, bus.dout[k]);
                end
            end
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (bus.dout[k] !== 8'd0) begin
                    n_mis++;
                    $display("FAIL reset_mid dout[%0d] got %0d exp 0", k, bus.dout[k]);
                end
            end
        end
        bus.up_en   = 1'b0;
        bus.down_en = 1'b0;
        rstn        = 1'b1;
    endtask

    task automatic test_up();
        for (int k = 0; k < 12; k++) begin
            bus.din     = v(k);
            bus.up_en   = 1'b1;
            bus.down_en = 1'b0;
            @(posedge clk); #1;
        end
        bus.up_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (bus.dout[k] !== v(11 - k)) begin
                n_mis++;
                $display("FAIL up dout[%0d] got %0d exp %0d", k, bus.dout[k], v(11 - k));
            end
        end
    endtask

    task automatic test_hold_async_reset();
        bus.up_en   = 1'b0;
        bus.down_en = 1'b0;
        bus.din     = 8'd255;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (bus.dout[k] !== v(11 - k)) begin
                n_mis++;
                $display("FAIL hold dout[%0d] got %0d exp %0d", k, bus.dout[k], v(11 - k));
            end
        end
        #2 rstn = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (bus.dout[k] !== 8'd0) begin
                n_mis++;
                $display("FAIL async_rst dout[%0d] got %0d exp 0", k, bus.dout[k]);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_down();
        for (int k = 0; k < 12; k++) begin
            bus.din     = v(k);
            bus.up_en   = 1'b0;
            bus.down_en = 1'b1;
            @(posedge clk); #1;
        end
        bus.down_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (bus.dout[k] !== v(1 + k)) begin
                n_mis++;
                $display("FAIL down dout[%0d] got %0d exp %0d", k, bus.dout[k], v(1 + k));
            end
        end
    endtask

    task automatic test_centre();
        logic [7:0] e;
        for (int k = 0; k < 12; k++) begin
            bus.din     = v(k);
            bus.up_en   = 1'b1;
            bus.down_en = 1'b1;
            @(posedge clk); #1;
        end
        bus.up_en   = 1'b0;
        bus.down_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = v(11 - ((k > C) ? (k - C) : (C - k)));
            n_cmp++;
            if (bus.dout[k] !== e) begin
                n_mis++;
                $display("FAIL centre dout[%0d] got %0d exp %0d", k, bus.dout[k], e);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] m  [N];
        logic [7:0] nm [N];
        logic [7:0] q  [$];
        logic       u;
        logic       d;
        logic [7:0] x;
        for (int k = 0; k < N; k++) m[k] = bus.dout[k];
        for (int cyc = 0; cyc < 300; cyc++) begin
            if ($urandom_range(0, 15) == 0) begin
                rstn = 1'b0;
                #1;
                for (int k = 0; k < N; k++) m[k] = 8'd0;
                for (int k = 0; k < N; k++) begin
                    n_cmp++;
                    if (bus.dout[k] !== 8'd0) begin
                        n_mis++;
                        $display("FAIL rand_rst cyc %0d dout[%0d] got %0d exp 0", cyc, k, bus.dout[k]);
                    end
                end
                rstn = 1'b1;
            end
            u = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            x = 8'($urandom_range(0, 255));
            bus.up_en   = u;
            bus.down_en = d;
            bus.din     = x;
            // Model: up/down as queue push/pop, centre as two half-shifts around C.
            q.delete();
            for (int k = 0; k < N; k++) q.push_back(m[k]);
            if (u && !d) begin
                q.push_front(x);
                void'(q.pop_back());
                for (int k = 0; k < N; k++) nm[k] = q[k];
            end else if (!u && d) begin
                q.push_back(x);
                void'(q.pop_front());
                for (int k = 0; k < N; k++) nm[k] = q[k];
            end else if (u && d) begin
                for (int k = 0; k < N; k++) begin
                    if (k == C)     nm[k] = x;
                    else if (k > C) nm[k] = m[k-1];
                    else            nm[k] = m[k+1];
                end
            end else begin
                for (int k = 0; k < N; k++) nm[k] = m[k];
            end
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) m[k] = nm[k];
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (bus.dout[k] !== m[k]) begin
                    n_mis++;
                    $display("FAIL rand cyc %0d dout[%0d] got %0d exp %0d", cyc, k, bus.dout[k], m[k]);
                end
            end
        end
        bus.up_en   = 1'b0;
        bus.down_en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_up();
        test_hold_async_reset();
        test_down();
        test_centre();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
